// File: rtl/flash_arbiter.sv
// Two-requester round-robin arbiter in front of the single Flash byte engine.
// Each grant runs one start/done transaction, with a watchdog abort on a missing fb_done.
module flash_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic          CLK_50MHZ,
  input  logic          RST,
  input  logic          req0_valid,
  input  logic          req0_rw,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic          req0_done,
  input  logic          req1_valid,
  input  logic          req1_rw,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic          req1_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic          fb_start,
  input  logic          fb_done,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          direction_rw,
  input  logic [DW-1:0] fb_rdata
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic          r_win;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_any;
  logic          w_sel;
  logic          w_timeout;

  assign w_any     = req0_valid | req1_valid;
  // Tie goes to whoever was not served last; otherwise the lone requester wins.
  assign w_sel     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_inc == CNT_LAST);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    fb_start  = 1'b0;
    req0_ack  = 1'b0;
    req1_ack  = 1'b0;
    req0_done = 1'b0;
    req1_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any) w_next = S_START;
      end
      S_START: begin
        fb_start = 1'b1;
        req0_ack = ~r_win;
        req1_ack = r_win;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        if (fb_done || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        req0_done = ~r_win;
        req1_done = r_win;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      r_last_grant <= 1'b1;
      r_win        <= 1'b0;
      r_cnt        <= '0;
      addr         <= '0;
      data         <= '0;
      direction_rw <= 1'b0;
      rdata        <= '0;
      err          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win        <= w_sel;
            addr         <= w_sel ? req1_addr  : req0_addr;
            data         <= w_sel ? req1_wdata : req0_wdata;
            direction_rw <= w_sel ? req1_rw    : req0_rw;
          end
        end
        S_START: r_cnt <= '0;
        S_WAIT: begin
          if (fb_done) begin
            if (direction_rw) rdata <= fb_rdata;
            err <= 1'b0;
          end else if (w_timeout) begin
            err <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: r_last_grant <= r_win;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: directed vector table, reset/spurious-done
// sequences, and randomized rounds checked against a transaction-level model.
module tb_flash_arbiter;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_rw, req0_ack, req0_done;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_rw, req1_ack, req1_done;
  logic [7:0] req1_addr, req1_wdata;
  logic [7:0] rdata, addr, data, fb_rdata;
  logic       err, busy, fb_start, fb_done, direction_rw;

  int         n_chk = 0;
  int         n_fail = 0;
  logic       m_last;
  logic [7:0] m_rdata;

  flash_arbiter #(.AW(8), .DW(8), .TIMEOUT(TO)) dut (
    .CLK_50MHZ(clk), .RST(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
    .rdata(rdata), .err(err), .busy(busy), .fb_start(fb_start), .fb_done(fb_done),
    .addr(addr), .data(data), .direction_rw(direction_rw), .fb_rdata(fb_rdata)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit v0; bit rw0; logic [7:0] a0; logic [7:0] d0;
    bit v1; bit rw1; logic [7:0] a1; logic [7:0] d1;
    int lat; logic [7:0] frd;
    bit ew; bit eerr; logic [7:0] erd;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; fb_done = 1'b0;
    req0_rw = 1'b0; req1_rw = 1'b0; fb_rdata = '0;
    req0_addr = '0; req0_wdata = '0; req1_addr = '0; req1_wdata = '0;
    step();
    step();
    rst = 1'b0;
    m_last  = 1'b1;
    m_rdata = '0;
  endtask

  // Engine latency lat: fb_done is high lat cycles after the fb_start cycle.
  // Latencies >= TO miss the watchdog window and must end as a timeout.
  task automatic serve_one(input bit w, input logic [7:0] ea, input logic [7:0] ed,
                           input bit erw, input int lat, input logic [7:0] frd,
                           input bit eerr, input logic [7:0] erd);
    int dcyc;
    dcyc = (lat < TO) ? lat + 1 : TO;
    step();
    chk("ack_winner", w ? req1_ack : req0_ack, 1);
    chk("ack_loser", w ? req0_ack : req1_ack, 0);
    chk("fb_start", fb_start, 1);
    chk("addr", addr, ea);
    chk("data", data, ed);
    chk("direction_rw", direction_rw, erw);
    if (w) begin
      req1_valid = 1'b0; req1_addr = 8'($urandom); req1_wdata = 8'($urandom);
    end else begin
      req0_valid = 1'b0; req0_addr = 8'($urandom); req0_wdata = 8'($urandom);
    end
    for (int c = 1; c <= dcyc; c++) begin
      step();
      fb_done  = (c == lat);
      fb_rdata = (c == lat) ? frd : 8'($urandom);
      chk("fb_start_low", fb_start, 0);
      chk("done", {req1_done, req0_done}, (c == dcyc) ? (w ? 2'b10 : 2'b01) : 2'b00);
      if (c == dcyc) begin
        chk("err", err, eerr);
        chk("rdata", rdata, erd);
        chk("busy_resp", busy, 1);
        chk("addr_held", addr, ea);
      end
    end
    step();
    fb_done = 1'b0;
    chk("busy_after", busy, 0);
    chk("done_after", {req1_done, req0_done}, 2'b00);
    m_last = w;
    if (lat < TO && erw) m_rdata = frd;
  endtask

  initial begin
    logic       p0, p1, w, rwv, e;
    int         lat;
    logic [7:0] frd, erd;

    tbl[0] = '{1'b1, 1'b0, 8'h35, 8'hC9, 1'b0, 1'b0, 8'h00, 8'h00,  5, 8'h5B, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h00,  3, 8'hA5, 1'b1, 1'b0, 8'hA5};
    tbl[2] = '{1'b1, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 16, 8'hFF, 1'b0, 1'b1, 8'hA5};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h30, 8'h00, 15, 8'h3C, 1'b1, 1'b0, 8'h3C};
    tbl[4] = '{1'b1, 1'b0, 8'h40, 8'h44, 1'b1, 1'b0, 8'h41, 8'h55,  1, 8'h99, 1'b0, 1'b0, 8'h3C};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h41, 8'h55,  2, 8'h98, 1'b1, 1'b0, 8'h3C};
    tbl[6] = '{1'b1, 1'b1, 8'h50, 8'h00, 1'b1, 1'b1, 8'h51, 8'h00,  4, 8'h61, 1'b0, 1'b0, 8'h61};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h51, 8'h00,  6, 8'h62, 1'b1, 1'b0, 8'h62};

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_fb_start", fb_start, 0);
    chk("rst_acks", {req1_ack, req0_ack}, 2'b00);
    chk("rst_dones", {req1_done, req0_done}, 2'b00);
    chk("rst_addr", addr, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_err", err, 0);
    chk("rst_dir", direction_rw, 0);

    for (int i = 0; i < 8; i++) begin
      req0_valid = tbl[i].v0; req0_rw = tbl[i].rw0; req0_addr = tbl[i].a0; req0_wdata = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_rw = tbl[i].rw1; req1_addr = tbl[i].a1; req1_wdata = tbl[i].d1;
      serve_one(tbl[i].ew, tbl[i].ew ? tbl[i].a1 : tbl[i].a0, tbl[i].ew ? tbl[i].d1 : tbl[i].d0,
                tbl[i].ew ? tbl[i].rw1 : tbl[i].rw0, tbl[i].lat, tbl[i].frd, tbl[i].eerr, tbl[i].erd);
    end

    // Tie straight after reset: requester 0 first, then the held requester 1.
    do_reset();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 8'h60; req0_wdata = 8'h61;
    req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 8'h62; req1_wdata = 8'h63;
    serve_one(1'b0, 8'h60, 8'h61, 1'b0, 2, 8'h11, 1'b0, 8'h00);
    serve_one(1'b1, 8'h62, 8'h63, 1'b1, 3, 8'h22, 1'b0, 8'h22);

    // Reset two cycles into WAIT of a requester-1 read.
    req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 8'h77; req1_wdata = 8'h00;
    step();
    chk("mid_ack1", req1_ack, 1);
    req1_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fb_start", fb_start, 0);
    chk("mid_rst_addr", addr, 8'h00);
    chk("mid_rst_rdata", rdata, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_rst_done", {req1_done, req0_done}, 2'b00);
    end
    rst = 1'b0;
    m_last = 1'b1;
    m_rdata = '0;
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 8'h0A; req0_wdata = 8'h0B;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 8'h0C; req1_wdata = 8'h0D;
    serve_one(1'b0, 8'h0A, 8'h0B, 1'b1, 4, 8'h44, 1'b0, 8'h44);
    serve_one(1'b1, 8'h0C, 8'h0D, 1'b0, 1, 8'h55, 1'b0, 8'h44);

    // Spurious fb_done while idle.
    fb_done = 1'b1; fb_rdata = 8'hEE;
    step();
    fb_done = 1'b0;
    chk("spur_busy", busy, 0);
    chk("spur_done", {req1_done, req0_done}, 2'b00);
    chk("spur_rdata", rdata, m_rdata);
    step();
    chk("spur_busy2", busy, 0);
    chk("spur_fb_start", fb_start, 0);
    chk("spur_rdata2", rdata, m_rdata);

    for (int r = 0; r < 60; r++) begin
      p0 = 1'($urandom);
      p1 = 1'($urandom);
      if (!p0 && !p1) p0 = 1'b1;
      req0_valid = p0; req0_rw = 1'($urandom); req0_addr = 8'($urandom); req0_wdata = 8'($urandom);
      req1_valid = p1; req1_rw = 1'($urandom); req1_addr = 8'($urandom); req1_wdata = 8'($urandom);
      while (p0 || p1) begin
        w   = (p0 && p1) ? ~m_last : p1;
        lat = $urandom_range(1, TO);
        frd = 8'($urandom);
        rwv = w ? req1_rw : req0_rw;
        e   = (lat >= TO);
        erd = (!e && rwv) ? frd : m_rdata;
        serve_one(w, w ? req1_addr : req0_addr, w ? req1_wdata : req0_wdata, rwv, lat, frd, e, erd);
        if (w) p1 = 1'b0;
        else   p0 = 1'b0;
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        fb_done = 1'($urandom); fb_rdata = 8'($urandom);
        step();
        chk("gap_done", {req1_done, req0_done}, 2'b00);
        chk("gap_rdata", rdata, m_rdata);
      end
      fb_done = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
